// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RISC-V M-extension multiply/divide with valid/ready handshake.
//            Define MULDIV_EARLY_OUT_EN to finish trivial ops in one edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  operand1,
  input  logic [XLEN-1:0]  operand2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int                CNT_W  = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state, w_next;
  logic [2:0]         r_op;
  logic [XLEN-1:0]    r_hi, r_lo, r_div;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg, r_neg_rem, r_early;
  logic [TAG_W-1:0]   r_tag_pend, r_out_tag;
  logic [XLEN-1:0]    r_result;

  logic               w_accept, w_sgn1, w_sgn2, w_neg1, w_neg2, w_div0, w_early;
  logic [XLEN-1:0]    w_mag1, w_mag2, w_early_res;

  assign in_ready  = (r_state == IDLE) & ~rst;
  assign w_accept  = in_valid & in_ready & ~flush;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == BUSY) | (r_state == DONE);
  assign result    = r_result;
  assign out_tag   = r_out_tag;

  // MUL takes the unsigned path: its low half is sign-independent.
  assign w_sgn1 = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
  assign w_sgn2 = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
  assign w_neg1 = w_sgn1 & operand1[XLEN-1];
  assign w_neg2 = w_sgn2 & operand2[XLEN-1];
  assign w_mag1 = w_neg1 ? -operand1 : operand1;
  assign w_mag2 = w_neg2 ? -operand2 : operand2;
  assign w_div0 = (operand2 == '0);

`ifdef MULDIV_EARLY_OUT_EN
  logic w_ovf;
  assign w_ovf = ((op == 3'b100) | (op == 3'b110)) &
                 (operand1 == {1'b1, {(XLEN-1){1'b0}}}) & (operand2 == '1);
  assign w_early = op[2] ? (w_div0 | w_ovf) : ((operand1 == '0) | (operand2 == '0));
  assign w_early_res = !op[2] ? '0 :
                       w_div0 ? (op[1] ? operand1 : '1) :
                                (op[1] ? '0 : operand1);
`else
  assign w_early     = 1'b0;
  assign w_early_res = '0;
`endif

  // One step of shift-add multiply and of restoring divide.
  logic [XLEN:0] w_msum, w_dshift, w_ddiff;
  logic          w_dok;
  assign w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_div} : '0);
  assign w_dshift = {r_hi, r_lo[XLEN-1]};
  assign w_ddiff  = w_dshift - {1'b0, r_div};
  assign w_dok    = ~w_ddiff[XLEN];

  // Sign fix-up; overflow falls out naturally, divide-by-zero clears r_neg at accept.
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_fix;
  assign w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_quo  = r_neg ? -r_lo : r_lo;
  assign w_rem  = r_neg_rem ? -r_hi : r_hi;

  always_comb begin
    w_fix = '0;
    if (r_early) begin
      w_fix = r_lo;
    end else begin
      case (r_op)
        3'b000:                 w_fix = w_prod[XLEN-1:0];
        3'b001, 3'b010, 3'b011: w_fix = w_prod[2*XLEN-1:XLEN];
        3'b100, 3'b101:         w_fix = w_quo;
        default:                w_fix = w_rem;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = BUSY;
      BUSY: begin
        if (flush)                w_next = IDLE;
        else if (r_cnt == C_LAST) w_next = DONE;
      end
      DONE: if (flush | out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div      <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_early    <= 1'b0;
      r_tag_pend <= '0;
      r_out_tag  <= '0;
      r_result   <= '0;
    end else if (w_accept) begin
      r_op       <= op;
      r_tag_pend <= in_tag;
      r_hi       <= '0;
      r_early    <= w_early;
      r_cnt      <= w_early ? C_LAST : '0;
      r_lo       <= w_early ? w_early_res : (op[2] ? w_mag1 : w_mag2);
      r_div      <= op[2] ? w_mag2 : w_mag1;
      r_neg      <= (w_neg1 ^ w_neg2) & ~(op[2] & w_div0);
      r_neg_rem  <= w_neg1;
    end else if (r_state == BUSY && !flush) begin
      if (r_cnt != C_LAST) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_op[2]) begin
          r_hi <= w_dok ? w_ddiff[XLEN-1:0] : w_dshift[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], w_dok};
        end else begin
          r_hi <= w_msum[XLEN:1];
          r_lo <= {w_msum[0], r_lo[XLEN-1:1]};
        end
      end else begin
        r_result  <= w_fix;
        r_out_tag <= r_tag_pend;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed vector table plus handshake/flush/reset sequences for muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = 3'b000;
  logic [XLEN-1:0]  operand1 = '0;
  logic [XLEN-1:0]  operand2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand1(operand1), .operand2(operand2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .busy(busy)
  );

  typedef struct {
    logic [2:0]       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  exp;
    bit               early;
  } vec_t;

  localparam logic [XLEN-1:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [XLEN-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op, wait (bounded) for out_valid, optionally consume it.
  task automatic run_op(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [TAG_W-1:0] t, input bit release_it,
                        output logic [XLEN-1:0] res, output logic [TAG_W-1:0] tg, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin @(negedge clk); w++; end
    in_valid = 1'b1; op = o; operand1 = a; operand2 = b; in_tag = t;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 150) begin
      @(posedge clk);
      #1 lat++;
    end
    res = result;
    tg  = out_tag;
    if (release_it) begin
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tg;
    int               lat;
    bit               seen;

    vecs[0]  = '{3'b000, 64'd7, -64'sd3, 5'd9, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
    vecs[1]  = '{3'b011, ONES, 64'd2, 5'd1, 64'd1, 1'b0};
    vecs[2]  = '{3'b001, ONES, ONES, 5'd2, 64'd0, 1'b0};
    vecs[3]  = '{3'b010, ONES, 64'd2, 5'd3, ONES, 1'b0};
    vecs[4]  = '{3'b100, -64'sd7, 64'd2, 5'd4, -64'sd3, 1'b0};
    vecs[5]  = '{3'b110, -64'sd7, 64'd2, 5'd5, ONES, 1'b0};
    vecs[6]  = '{3'b101, 64'd100, 64'd7, 5'd6, 64'd14, 1'b0};
    vecs[7]  = '{3'b111, 64'd100, 64'd7, 5'd7, 64'd2, 1'b0};
    vecs[8]  = '{3'b101, 64'd5, 64'd0, 5'd8, ONES, 1'b1};
    vecs[9]  = '{3'b110, 64'd5, 64'd0, 5'd10, 64'd5, 1'b1};
    vecs[10] = '{3'b100, MIN, ONES, 5'd11, MIN, 1'b1};
    vecs[11] = '{3'b110, MIN, ONES, 5'd12, 64'd0, 1'b1};
    vecs[12] = '{3'b000, 64'd0, 64'd12345, 5'd13, 64'd0, 1'b1};
    vecs[13] = '{3'b000, 64'h1_2345_6789, 64'h1000, 5'd14, 64'h1234_5678_9000, 1'b0};
    vecs[14] = '{3'b011, MIN, 64'd4, 5'd15, 64'd2, 1'b0};
    vecs[15] = '{3'b001, MIN, 64'd2, 5'd16, ONES, 1'b0};
    vecs[16] = '{3'b101, 64'd7, 64'd100, 5'd17, 64'd0, 1'b0};
    vecs[17] = '{3'b110, 64'd7, -64'sd2, 5'd18, 64'd1, 1'b0};
    vecs[18] = '{3'b100, 64'd7, -64'sd2, 5'd31, -64'sd3, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1 check("in_ready_in_rst", {63'b0, in_ready}, 64'd0);
    check("out_valid_rst", {63'b0, out_valid}, 64'd0);
    check("busy_rst", {63'b0, busy}, 64'd0);
    check("result_rst", result, 64'd0);
    check("out_tag_rst", {59'b0, out_tag}, 64'd0);
    @(negedge clk) rst = 1'b0;
    #1 check("in_ready_idle", {63'b0, in_ready}, 64'd1);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b1, res, tg, lat);
      check($sformatf("result[%0d]", i), res, vecs[i].exp);
      check($sformatf("tag[%0d]", i), {59'b0, tg}, {59'b0, vecs[i].tag});
      check($sformatf("latency[%0d]", i), 64'(lat), (vecs[i].early && EARLY) ? 64'd1 : 64'd65);
      check($sformatf("valid_drop[%0d]", i), {63'b0, out_valid}, 64'd0);
    end

    // Hold in DONE with out_ready low; a new in_valid must not be taken
    run_op(3'b101, 64'd100, 64'd7, 5'd3, 1'b0, res, tg, lat);
    @(negedge clk);
    in_valid = 1'b1; op = 3'b000; operand1 = 64'd2; operand2 = 64'd3; in_tag = 5'd20;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("hold_valid", {63'b0, out_valid}, 64'd1);
      check("hold_result", result, 64'd14);
      check("hold_ready", {63'b0, in_ready}, 64'd0);
    end
    check("hold_tag", {59'b0, out_tag}, 64'd3);
    in_valid = 1'b0;
    // flush in DONE
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_done_valid", {63'b0, out_valid}, 64'd0);
    check("flush_done_busy", {63'b0, busy}, 64'd0);

    // flush in IDLE blocks a same-cycle request
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 3'b101; operand1 = 64'd9; operand2 = 64'd3;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_busy", {63'b0, busy}, 64'd0);

    // flush mid-DIV after E20
    @(negedge clk);
    in_valid = 1'b1; op = 3'b100; operand1 = 64'd1000; operand2 = 64'd3; in_tag = 5'd21;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy_ready", {63'b0, in_ready}, 64'd1);
    check("flush_busy_busy", {63'b0, busy}, 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    check("flush_no_valid", {63'b0, seen}, 64'd0);

    // rst at E30 of a MUL
    @(negedge clk);
    in_valid = 1'b1; op = 3'b000; operand1 = 64'd5; operand2 = 64'd6; in_tag = 5'd22;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_valid", {63'b0, out_valid}, 64'd0);
    check("rst_mid_busy", {63'b0, busy}, 64'd0);
    check("rst_mid_result", result, 64'd0);
    check("rst_mid_tag", {59'b0, out_tag}, 64'd0);
    @(negedge clk) rst = 1'b0;

    // Recovery after reset
    run_op(3'b000, 64'd5, 64'd6, 5'd23, 1'b1, res, tg, lat);
    check("recover_result", res, 64'd30);
    check("recover_latency", 64'(lat), 64'd65);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
